// File: rtl/fxp_round_sched.sv
// ---------------------------------------------------------------------------
// fxp_round_sched
//
// Shared front-end of the vector fixed-point rounding stage. Two requesters,
// the averaging-add unit (A) and the scaling-shift unit (B), compete for a
// single two-register pipeline. A burst that starts with last = 0 locks the
// arbiter to its owner until the owner's last beat is accepted. Without a
// lock, simultaneous requests alternate round-robin, and A wins after reset.
//
// Stage 1 captures the granted beat. Stage 2 (the output register) holds the
// beat after it has been shifted right by one bit, with vxrm rounding applied
// independently inside each SEW-wide lane.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   a_valid / a_ready        requester A handshake
//   a_sum, a_carry           pre-shift lane sums and per-byte carry bits
//   a_vxrm, a_sew            rounding mode and element width of the beat
//   a_last, a_tag            burst terminator and opaque requester tag
//   b_*                      same set for requester B
//   out_valid / out_ready    result handshake with full backpressure
//   out_data                 rounded packed result
//   out_tag, out_src,        tag, source (0 = A, 1 = B) and last flag of the
//   out_last                 beat currently presented
//   busy                     a stage holds a beat or a burst lock is held
// ---------------------------------------------------------------------------
module fxp_round_sched #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [DATA_WIDTH-1:0]   a_sum,
    input  logic [DATA_WIDTH/8-1:0] a_carry,
    input  logic [1:0]              a_vxrm,
    input  logic [1:0]              a_sew,
    input  logic                    a_last,
    input  logic [TAG_WIDTH-1:0]    a_tag,

    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [DATA_WIDTH-1:0]   b_sum,
    input  logic [DATA_WIDTH/8-1:0] b_carry,
    input  logic [1:0]              b_vxrm,
    input  logic [1:0]              b_sew,
    input  logic                    b_last,
    input  logic [TAG_WIDTH-1:0]    b_tag,

    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [TAG_WIDTH-1:0]    out_tag,
    output logic                    out_src,
    output logic                    out_last,

    output logic                    busy
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;

    // Burst lock owner. LOCK_NONE means the round-robin arbiter is free.
    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_A    = 2'd1,
        LOCK_B    = 2'd2
    } lock_t;

    lock_t                  lock_q;
    logic                   prefer_b_q;

    logic                   adv;
    logic                   grant_a;
    logic                   grant_b;
    logic                   accept_a;
    logic                   accept_b;
    logic                   accept;

    logic [DATA_WIDTH-1:0]  sel_sum;
    logic [NUM_BYTES-1:0]   sel_carry;
    logic [1:0]             sel_vxrm;
    logic [1:0]             sel_sew;
    logic                   sel_last;
    logic [TAG_WIDTH-1:0]   sel_tag;

    logic                   s1_valid;
    logic [DATA_WIDTH-1:0]  s1_sum;
    logic [NUM_BYTES-1:0]   s1_carry;
    logic [1:0]             s1_vxrm;
    logic [1:0]             s1_sew;
    logic                   s1_last;
    logic [TAG_WIDTH-1:0]   s1_tag;
    logic                   s1_src;

    logic [8:0]             v8;
    logic [16:0]            v16;
    logic [32:0]            v32;
    logic [64:0]            v64;
    logic [DATA_WIDTH-1:0]  res8;
    logic [DATA_WIDTH-1:0]  res16;
    logic [DATA_WIDTH-1:0]  res32;
    logic [DATA_WIDTH-1:0]  res64;
    logic [DATA_WIDTH-1:0]  round_data;

    // Rounding increment for a one-bit right shift: b0 is the bit shifted
    // out, b1 is the new least significant bit of the quotient.
    function automatic logic round_inc(input logic [1:0] mode,
                                       input logic       b1,
                                       input logic       b0);
        logic r;
        r = 1'b0;
        case (mode)
            2'b00:   r = b0;
            2'b01:   r = b0 & b1;
            2'b10:   r = 1'b0;
            default: r = b0 & ~b1;
        endcase
        return r;
    endfunction

    // The whole pipeline moves whenever the output register is empty or is
    // being drained this cycle.
    assign adv = ~out_valid | out_ready;

    // Grant selection. A held lock pins the grant to its owner even while the
    // owner is idle, so the other side cannot slip into the middle of a burst.
    // Without a lock a lone requester wins, and a tie goes to the side that
    // was not granted last. Nothing is granted while reset is asserted.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst && adv) begin
            case (lock_q)
                LOCK_A: grant_a = 1'b1;
                LOCK_B: grant_b = 1'b1;
                default: begin
                    if (a_valid && (!b_valid || !prefer_b_q)) begin
                        grant_a = 1'b1;
                    end else if (b_valid) begin
                        grant_b = 1'b1;
                    end
                end
            endcase
        end
    end

    assign a_ready  = grant_a & adv;
    assign b_ready  = grant_b & adv;
    assign accept_a = a_valid & a_ready;
    assign accept_b = b_valid & b_ready;
    assign accept   = accept_a | accept_b;

    // Steer the accepted requester's fields toward stage 1. At most one side
    // can be accepted in a cycle, so a two-way mux on accept_b is enough.
    always_comb begin
        sel_sum   = a_sum;
        sel_carry = a_carry;
        sel_vxrm  = a_vxrm;
        sel_sew   = a_sew;
        sel_last  = a_last;
        sel_tag   = a_tag;
        if (accept_b) begin
            sel_sum   = b_sum;
            sel_carry = b_carry;
            sel_vxrm  = b_vxrm;
            sel_sew   = b_sew;
            sel_last  = b_last;
            sel_tag   = b_tag;
        end
    end

    // Lock and round-robin state. Both only move on an accepted beat, so a
    // stalled pipeline leaves them untouched. After a grant to A the tie-break
    // favours B next, and vice versa.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q     <= LOCK_NONE;
            prefer_b_q <= 1'b0;
        end else if (accept) begin
            prefer_b_q <= accept_a;
            if (sel_last) begin
                lock_q <= LOCK_NONE;
            end else if (accept_b) begin
                lock_q <= LOCK_B;
            end else begin
                lock_q <= LOCK_A;
            end
        end
    end

    // Stage 1 register. It refills on every advance; a cycle that advances
    // without an accept leaves a bubble, marked by s1_valid = 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_carry <= '0;
            s1_vxrm  <= '0;
            s1_sew   <= '0;
            s1_last  <= 1'b0;
            s1_tag   <= '0;
            s1_src   <= 1'b0;
        end else if (adv) begin
            s1_valid <= accept;
            if (accept) begin
                s1_sum   <= sel_sum;
                s1_carry <= sel_carry;
                s1_vxrm  <= sel_vxrm;
                s1_sew   <= sel_sew;
                s1_last  <= sel_last;
                s1_tag   <= sel_tag;
                s1_src   <= accept_b;
            end
        end
    end

    // Lane-local rounding of the stage 1 beat for every element width. Each
    // lane forms {carry, sum} from the carry bit of its most significant byte,
    // drops the low bit and adds the rounding increment. The sum is truncated
    // to the lane width, so a wrap never reaches the neighbouring lane. The
    // element width of the beat selects one of the four results.
    always_comb begin
        v8    = '0;
        v16   = '0;
        v32   = '0;
        v64   = '0;
        res8  = '0;
        res16 = '0;
        res32 = '0;
        res64 = '0;
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            v8 = {s1_carry[i], s1_sum[i*8 +: 8]};
            res8[i*8 +: 8] = v8[8:1] + {7'd0, round_inc(s1_vxrm, v8[1], v8[0])};
        end
        for (int i = 0; i < DATA_WIDTH / 16; i++) begin
            v16 = {s1_carry[i*2+1], s1_sum[i*16 +: 16]};
            res16[i*16 +: 16] = v16[16:1] + {15'd0, round_inc(s1_vxrm, v16[1], v16[0])};
        end
        for (int i = 0; i < DATA_WIDTH / 32; i++) begin
            v32 = {s1_carry[i*4+3], s1_sum[i*32 +: 32]};
            res32[i*32 +: 32] = v32[32:1] + {31'd0, round_inc(s1_vxrm, v32[1], v32[0])};
        end
        for (int i = 0; i < DATA_WIDTH / 64; i++) begin
            v64 = {s1_carry[i*8+7], s1_sum[i*64 +: 64]};
            res64[i*64 +: 64] = v64[64:1] + {63'd0, round_inc(s1_vxrm, v64[1], v64[0])};
        end
        case (s1_sew)
            2'b00:   round_data = res8;
            2'b01:   round_data = res16;
            2'b10:   round_data = res32;
            default: round_data = res64;
        endcase
    end

    // Output register. It loads on the same advance as stage 1, so a drain
    // and a new accept in one cycle shift the pipeline with no bubble. While
    // stalled, every out_* field holds its value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_src   <= 1'b0;
            out_last  <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_valid;
            out_data  <= round_data;
            out_tag   <= s1_tag;
            out_src   <= s1_src;
            out_last  <= s1_last;
        end
    end

    assign busy = s1_valid | out_valid | (lock_q != LOCK_NONE);

endmodule
